// File: rtl/chen_keygen_if.sv
// Key generator control/key-stream bundle.
//  master: start/abort pulses, seeds, coefficients, step, counts, key_ready
//  slave : key_out/key_valid stream plus busy, done and sticky sat_flag status
interface chen_keygen_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned KEY_W = 8,
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] seed_x;
   logic [WIDTH-1:0] seed_y;
   logic [WIDTH-1:0] seed_z;
   logic [WIDTH-1:0] coef_a;
   logic [WIDTH-1:0] coef_b;
   logic [WIDTH-1:0] coef_c;
   logic [WIDTH-1:0] step_h;
   logic [CNT_W-1:0] warmup;
   logic [CNT_W-1:0] num_keys;
   logic [KEY_W-1:0] key_out;
   logic             key_valid;
   logic             key_ready;
   logic             busy;
   logic             done;
   logic             sat_flag;

   modport master (
      output start, abort, seed_x, seed_y, seed_z, coef_a, coef_b, coef_c,
             step_h, warmup, num_keys, key_ready,
      input  key_out, key_valid, busy, done, sat_flag
   );

   modport slave (
      input  start, abort, seed_x, seed_y, seed_z, coef_a, coef_b, coef_c,
             step_h, warmup, num_keys, key_ready,
      output key_out, key_valid, busy, done, sat_flag
   );
endinterface

// File: rtl/chen_keygen_core.sv
// Chen-attractor key generator: forward-Euler integration of the Chen system in
// saturating signed fixed point, one iteration per clock, optional warm-up, and a
// valid/ready key stream.
//  clk, rst : clock (rising edge), asynchronous active-high reset
//  bus      : chen_keygen_if.slave (control, seeds/coefs, key stream, status)
module chen_keygen_core #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16,
   parameter int unsigned KEY_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   chen_keygen_if.slave    bus
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam logic signed [W2-1:0] MAX_L = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [W2-1:0] MIN_L = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DRAIN} state_t;

   // Saturating add/sub; result is {saturated, value}.
   function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] q,
                                              input logic sub);
      logic signed [WIDTH:0] pe, qe, s;
      pe = {p[WIDTH-1], p};
      qe = {q[WIDTH-1], q};
      s  = sub ? (pe - qe) : (pe + qe);
      if (s[WIDTH] != s[WIDTH-1])
         return {1'b1, s[WIDTH], {(WIDTH-1){~s[WIDTH]}}};
      return {1'b0, s[WIDTH-1:0]};
   endfunction

   // Fixed-point multiply, floor-rounded by the arithmetic shift; {saturated, value}.
   function automatic logic [WIDTH:0] sat_mul(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] q);
      logic signed [W2-1:0] pe, qe, pr;
      pe = {{WIDTH{p[WIDTH-1]}}, p};
      qe = {{WIDTH{q[WIDTH-1]}}, q};
      pr = (pe * qe) >>> FRAC;
      if (pr > MAX_L) return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
      if (pr < MIN_L) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      return {1'b0, pr[WIDTH-1:0]};
   endfunction

   state_t           state, state_n;
   logic [WIDTH-1:0] x, y, z, a, b, c, h;
   logic [WIDTH-1:0] x_n, y_n, z_n, a_n, b_n, c_n, h_n;
   logic [CNT_W-1:0] nk, wcnt, kcnt;
   logic [CNT_W-1:0] nk_n, wcnt_n, kcnt_n, kcnt_inc;
   logic [KEY_W-1:0] key_q, key_n;
   logic             valid_q, valid_n, done_q, done_n, busy_q, busy_n, sat_q, sat_n;
   logic             commit;

   logic [WIDTH:0]   r_yx, r_dx, r_ca, r_m1, r_m2, r_m3, r_t1, r_dy;
   logic [WIDTH:0]   r_m4, r_m5, r_dz, r_hx, r_hy, r_hz, r_nx, r_ny, r_nz;
   logic [WIDTH-1:0] mix;
   logic [KEY_W-1:0] key_c;
   logic             step_sat;

   // One Euler step from the current state and latched coefficients.
   always_comb begin
      r_yx = sat_add(y, x, 1'b1);
      r_dx = sat_mul(a, r_yx[WIDTH-1:0]);
      r_ca = sat_add(c, a, 1'b1);
      r_m1 = sat_mul(r_ca[WIDTH-1:0], x);
      r_m2 = sat_mul(x, z);
      r_m3 = sat_mul(c, y);
      r_t1 = sat_add(r_m1[WIDTH-1:0], r_m2[WIDTH-1:0], 1'b1);
      r_dy = sat_add(r_t1[WIDTH-1:0], r_m3[WIDTH-1:0], 1'b0);
      r_m4 = sat_mul(x, y);
      r_m5 = sat_mul(b, z);
      r_dz = sat_add(r_m4[WIDTH-1:0], r_m5[WIDTH-1:0], 1'b1);
      r_hx = sat_mul(h, r_dx[WIDTH-1:0]);
      r_hy = sat_mul(h, r_dy[WIDTH-1:0]);
      r_hz = sat_mul(h, r_dz[WIDTH-1:0]);
      r_nx = sat_add(x, r_hx[WIDTH-1:0], 1'b0);
      r_ny = sat_add(y, r_hy[WIDTH-1:0], 1'b0);
      r_nz = sat_add(z, r_hz[WIDTH-1:0], 1'b0);
      mix  = r_nx[WIDTH-1:0] ^ r_ny[WIDTH-1:0] ^ r_nz[WIDTH-1:0];
      key_c = mix[KEY_W-1:0];
      step_sat = r_yx[WIDTH] | r_dx[WIDTH] | r_ca[WIDTH] | r_m1[WIDTH] | r_m2[WIDTH]
               | r_m3[WIDTH] | r_t1[WIDTH] | r_dy[WIDTH] | r_m4[WIDTH] | r_m5[WIDTH]
               | r_dz[WIDTH] | r_hx[WIDTH] | r_hy[WIDTH] | r_hz[WIDTH] | r_nx[WIDTH]
               | r_ny[WIDTH] | r_nz[WIDTH];
   end

   assign kcnt_inc = kcnt + CNT_W'(1);

   // Next-state and next-register logic.
   always_comb begin
      state_n = state;
      x_n = x;  y_n = y;  z_n = z;
      a_n = a;  b_n = b;  c_n = c;  h_n = h;
      nk_n    = nk;
      wcnt_n  = wcnt;
      kcnt_n  = kcnt;
      key_n   = key_q;
      valid_n = valid_q;
      done_n  = 1'b0;
      sat_n   = sat_q;
      commit  = 1'b0;

      if (bus.abort) begin
         state_n = S_IDLE;
         valid_n = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x_n = bus.seed_x;  y_n = bus.seed_y;  z_n = bus.seed_z;
                  a_n = bus.coef_a;  b_n = bus.coef_b;  c_n = bus.coef_c;
                  h_n = bus.step_h;
                  nk_n   = bus.num_keys;
                  wcnt_n = bus.warmup;
                  kcnt_n = '0;
                  sat_n  = 1'b0;
                  state_n = (bus.warmup != '0) ? S_WARM : S_RUN;
               end
            end
            S_WARM: begin
               commit = 1'b1;
               wcnt_n = wcnt - CNT_W'(1);
               if (wcnt == CNT_W'(1)) state_n = S_RUN;
            end
            S_RUN: begin
               // Iterate only when the output register is free; otherwise stall.
               if (!valid_q || bus.key_ready) begin
                  commit  = 1'b1;
                  key_n   = key_c;
                  valid_n = 1'b1;
                  if (kcnt != '1) kcnt_n = kcnt_inc;
                  if ((nk != '0) && (kcnt_inc == nk)) state_n = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (valid_q && bus.key_ready) begin
                  valid_n = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_IDLE;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end

      if (commit) begin
         x_n = r_nx[WIDTH-1:0];
         y_n = r_ny[WIDTH-1:0];
         z_n = r_nz[WIDTH-1:0];
         if (step_sat) sat_n = 1'b1;
      end

      busy_n = (state_n != S_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         x <= '0;  y <= '0;  z <= '0;
         a <= '0;  b <= '0;  c <= '0;  h <= '0;
         nk      <= '0;
         wcnt    <= '0;
         kcnt    <= '0;
         key_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state   <= state_n;
         x <= x_n;  y <= y_n;  z <= z_n;
         a <= a_n;  b <= b_n;  c <= c_n;  h <= h_n;
         nk      <= nk_n;
         wcnt    <= wcnt_n;
         kcnt    <= kcnt_n;
         key_q   <= key_n;
         valid_q <= valid_n;
         done_q  <= done_n;
         busy_q  <= busy_n;
         sat_q   <= sat_n;
      end
   end

   assign bus.key_out   = key_q;
   assign bus.key_valid = valid_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_chen_keygen_core.sv
// Bench for chen_keygen_core: directed runs push expected keys into a queue,
// a negedge monitor pops and compares on every accepted key and checks that a
// stalled key never changes.
module tb_chen_keygen_core;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned FRAC  = 16;
   localparam int unsigned KEY_W = 8;
   localparam int unsigned CNT_W = 16;

   localparam logic [31:0] CA = 32'h0023_0000;
   localparam logic [31:0] CB = 32'h0003_0000;
   localparam logic [31:0] CC = 32'h001C_0000;
   localparam logic [31:0] H0 = 32'd655;
   localparam logic [31:0] ONE = 32'h0001_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   chen_keygen_if #(.WIDTH(WIDTH), .KEY_W(KEY_W), .CNT_W(CNT_W)) bus ();

   chen_keygen_core #(.WIDTH(WIDTH), .FRAC(FRAC), .KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor.
   logic       held;
   logic [7:0] held_key;
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held && bus.key_valid) check("stall_hold", 64'(bus.key_out), 64'(held_key));
         if (bus.key_valid && bus.key_ready) begin
            if (exp_q.size() == 0) check("unexpected_key", 64'(bus.key_out), 64'hDEAD);
            else check("key", 64'(bus.key_out), 64'(exp_q.pop_front()));
         end
         held     = bus.key_valid && !bus.key_ready;
         held_key = bus.key_out;
      end
   end

   // Reference model of one Euler step (64-bit integer arithmetic).
   function automatic longint msat(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction
   function automatic longint mmul(input longint p, input longint q);
      return msat((p * q) >>> FRAC);
   endfunction
   task automatic mstep(inout longint x, inout longint y, inout longint z,
                        input longint h, output logic [7:0] key);
      longint a, b, c, dx, dy, dz, xn, yn, zn, mx;
      a = longint'(signed'(CA)); b = longint'(signed'(CB)); c = longint'(signed'(CC));
      dx = mmul(a, msat(y - x));
      dy = msat(msat(mmul(msat(c - a), x) - mmul(x, z)) + mmul(c, y));
      dz = msat(mmul(x, y) - mmul(b, z));
      xn = msat(x + mmul(h, dx));
      yn = msat(y + mmul(h, dy));
      zn = msat(z + mmul(h, dz));
      x = xn; y = yn; z = zn;
      mx = xn ^ yn ^ zn;
      key = mx[7:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic [31:0] seed, input logic [31:0] h,
                        input int warm, input int nkeys);
      bus.seed_x = seed; bus.seed_y = seed; bus.seed_z = seed;
      bus.coef_a = CA;   bus.coef_b = CB;   bus.coef_c = CC;
      bus.step_h = h;
      bus.warmup = CNT_W'(warm);
      bus.num_keys = CNT_W'(nkeys);
   endtask

   task automatic pulse_start();
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Counts edges from the start-sampling edge until key_valid appears.
   task automatic wait_valid(input int exp_k);
      int k;
      bit got;
      k = 1;
      got = 1'b0;
      while (k < 40 && !got) begin
         tick();
         k++;
         if (bus.key_valid) got = 1'b1;
      end
      check("first_key_latency", 64'(k), 64'(exp_k));
   endtask

   task automatic wait_done(input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (bus.done) got = 1'b1;
      end
      check("done_pulse", 64'(got), 64'd1);
   endtask

   initial begin
      logic [7:0] k11, k12, kd;
      longint mx, my, mz;

      rst = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.key_ready = 1'b0;
      setup('0, H0, 0, 0);
      tick(); tick();
      check("rst_key_out",   64'(bus.key_out),   64'd0);
      check("rst_key_valid", 64'(bus.key_valid), 64'd0);
      check("rst_busy",      64'(bus.busy),      64'd0);
      check("rst_done",      64'(bus.done),      64'd0);
      check("rst_sat",       64'(bus.sat_flag),  64'd0);
      rst = 1'b0;
      tick();

      // Zero fixed point: four zero keys.
      setup('0, H0, 0, 4);
      bus.key_ready = 1'b1;
      repeat (4) exp_q.push_back(8'h00);
      pulse_start();
      check("t1_busy", 64'(bus.busy), 64'd1);
      wait_done(20);
      check("t1_sat", 64'(bus.sat_flag), 64'd0);
      check("t1_idle", 64'(bus.busy), 64'd0);
      check("t1_drained", 64'(exp_q.size()), 64'd0);

      // One step from (1,1,1).
      setup(ONE, H0, 0, 1);
      exp_q.push_back(8'hCE);
      pulse_start();
      wait_valid(2);
      wait_done(10);
      check("t2_sat", 64'(bus.sat_flag), 64'd0);

      // Backpressure: three keys, ready low for five cycles after the first.
      setup(ONE, H0, 0, 3);
      exp_q.push_back(8'hCE); exp_q.push_back(8'h3F); exp_q.push_back(8'h49);
      pulse_start();
      wait_valid(2);
      tick();
      bus.key_ready = 1'b0;
      repeat (5) tick();
      check("t3_stalled_valid", 64'(bus.key_valid), 64'd1);
      bus.key_ready = 1'b1;
      wait_done(10);
      check("t3_drained", 64'(exp_q.size()), 64'd0);

      // Warm-up of 10: keys are the 11th and 12th iterates.
      mx = 64'sd65536; my = 64'sd65536; mz = 64'sd65536;
      k11 = '0; k12 = '0;
      for (int i = 0; i < 11; i++) mstep(mx, my, mz, 64'sd655, k11);
      mstep(mx, my, mz, 64'sd655, k12);
      setup(ONE, H0, 10, 2);
      exp_q.push_back(k11); exp_q.push_back(k12);
      pulse_start();
      wait_valid(12);
      wait_done(10);

      // Saturation: near-max seeds with h = 1.0.
      setup(32'h7FFF_0000, ONE, 0, 1);
      exp_q.push_back(8'hFF);
      pulse_start();
      wait_done(10);
      check("t5_sat", 64'(bus.sat_flag), 64'd1);

      // Start while busy is ignored; new start clears sat_flag.
      setup(ONE, H0, 0, 1);
      bus.key_ready = 1'b0;
      pulse_start();
      wait_valid(2);
      check("t6_sat_cleared", 64'(bus.sat_flag), 64'd0);
      setup('0, H0, 0, 5);
      pulse_start();
      tick();
      exp_q.push_back(8'hCE);
      bus.key_ready = 1'b1;
      wait_done(10);

      // Free-running, then abort while a key is stalled.
      setup(ONE, H0, 0, 0);
      bus.key_ready = 1'b0;
      pulse_start();
      wait_valid(2);
      exp_q.push_back(8'hCE); exp_q.push_back(8'h3F); exp_q.push_back(8'h49);
      bus.key_ready = 1'b1;
      repeat (3) tick();
      bus.key_ready = 1'b0;
      tick();
      check("t6_free_running", 64'(bus.busy), 64'd1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_valid", 64'(bus.key_valid), 64'd0);
      check("abort_busy",  64'(bus.busy),      64'd0);
      for (int i = 0; i < 3; i++) begin
         check("abort_no_done", 64'(bus.done), 64'd0);
         tick();
      end
      check("abort_drained", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the middle of a long warm-up.
      setup(ONE, H0, 100, 1);
      bus.key_ready = 1'b1;
      pulse_start();
      repeat (3) tick();
      check("warm_busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      kd = bus.key_out;
      check("arst_busy",      64'(bus.busy),      64'd0);
      check("arst_key_valid", 64'(bus.key_valid), 64'd0);
      check("arst_key_out",   64'(kd),            64'd0);
      check("arst_done",      64'(bus.done),      64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
